// File: rtl/board_ram_arb_pkg.sv
// Shared constants and types for the board RAM arbiter: requester indices,
// controller state encoding and default geometry of the 10x20 board store.
package board_ram_arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int REQ_PIECE = 0;
  localparam int REQ_CLEAR = 1;
  localparam int REQ_READ  = 2;

  localparam int DEF_AW    = 8;
  localparam int DEF_DW    = 6;
  localparam int DEF_DEPTH = 200;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/board_ram_arb_pick.sv
// Requester selector: grants the first active request found when searching
// upward from ptr (wrapping 2 -> 0); ptr = 0 gives fixed priority 0 > 1 > 2.
module arb_pick
  import board_ram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    logic [2:0] pos;
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + 3'(i);
      if (pos >= 3'd3) pos = pos - 3'd3;
      if (req[pos[1:0]] && (gnt == 3'b000)) gnt[pos[1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/board_ram_arb.sv
// Three-way arbiter in front of a single-port board RAM with ownership lock.
// Define BOARD_ARB_RR_EN for round-robin arbitration when no owner holds the RAM.
module board_ram_arb
  import board_ram_arb_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [2:0]    req,
  input  logic [2:0]    we,
  input  logic [2:0]    lock,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wren,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q
);

  arb_state_e    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    ptr;
  logic [2:0]    pick_gnt;
  logic          use_owner;
  logic          granted;
  logic [1:0]    gidx;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gwdata;
  logic          gwe;
  logic          in_range;
  logic [2:0]    rd_pend_q;
  logic          rd_oor_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rd_word;

`ifdef BOARD_ARB_RR_EN
  logic [1:0] rr_ptr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      rr_ptr_q <= 2'd0;
    else if (granted) rr_ptr_q <= next_idx(gidx);
  end

  assign ptr = rr_ptr_q;
`else
  assign ptr = 2'd0;
`endif

  arb_pick u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt)
  );

  // An owner that drops lock is arbitrated like everyone else that same cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    owner_d   = owner_q;
    gnt       = '0;
    use_owner = (state_q == OWNED) && lock[owner_q];
    if (use_owner) begin
      gnt[owner_q] = req[owner_q];
    end else begin
      gnt = pick_gnt;
      if ((pick_gnt & lock) != 3'b000) begin
        state_d = OWNED;
        owner_d = onehot_to_idx(pick_gnt);
      end else begin
        state_d = IDLE;
      end
    end
    // NOTE: gnt is combinational from req, so it is masked explicitly during reset.
    if (!resetn) gnt = '0;
  end

  always_comb begin
    granted = (gnt != 3'b000);
    gidx    = onehot_to_idx(gnt);
    gaddr   = '0;
    gwdata  = '0;
    gwe     = 1'b0;
    if (granted) begin
      case (gidx)
        2'd0:    begin gaddr = addr0; gwdata = wdata0; gwe = we[0]; end
        2'd1:    begin gaddr = addr1; gwdata = wdata1; gwe = we[1]; end
        default: begin gaddr = addr2; gwdata = wdata2; gwe = we[2]; end
      endcase
    end
    in_range = (32'(gaddr) < DEPTH);
  end

  assign ram_addr = gaddr;
  assign ram_data = gwdata;
  assign ram_wren = granted && gwe && in_range;
  assign err      = granted && !in_range;

  // NOTE: state is updated with <= so every flop samples the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      rd_pend_q <= '0;
      rd_oor_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rd_pend_q <= gnt & ~we;
      rd_oor_q  <= granted && !gwe && !in_range;
      if (rd_pend_q != 3'b000) rdata_q <= rd_word;
    end
  end

  // Out-of-range reads return zero instead of whatever the RAM presents.
  assign rd_word = rd_oor_q ? '0 : ram_q;
  assign rvalid  = rd_pend_q;
  assign rdata   = (rd_pend_q != 3'b000) ? rd_word : rdata_q;

endmodule

// File: tb/tb_board_ram_arb.sv
// Directed bench for board_ram_arb with a behavioural single-port RAM
// (one-cycle registered read); inputs change on negedge, outputs checked just after.
module tb_board_ram_arb;

  logic       clk;
  logic       resetn;
  logic [2:0] req, we, lock;
  logic [7:0] addr0, addr1, addr2;
  logic [5:0] wdata0, wdata1, wdata2;
  logic [2:0] gnt, rvalid;
  logic [5:0] rdata;
  logic       err;
  logic [7:0] ram_addr;
  logic       ram_wren;
  logic [5:0] ram_data;
  logic [5:0] ram_q;

  logic       pl_en;
  logic [7:0] pl_addr;
  logic [5:0] pl_data;
  logic [5:0] mem [256];

  int checks;
  int errors;

  board_ram_arb dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .we       (we),
    .lock     (lock),
    .addr0    (addr0),
    .addr1    (addr1),
    .addr2    (addr2),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .wdata2   (wdata2),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err),
    .ram_addr (ram_addr),
    .ram_wren (ram_wren),
    .ram_data (ram_data),
    .ram_q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)         mem[pl_addr] <= pl_data;
    else if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic idle_inputs();
    req = '0; we = '0; lock = '0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
  endtask

  task automatic test_reset();
    logic [7:0] pa [3];
    logic [5:0] pd [3];
    pa[0] = 8'd5;   pd[0] = 6'h2A;
    pa[1] = 8'd255; pd[1] = 6'h15;
    pa[2] = 8'd200; pd[2] = 6'h07;
    resetn = 1'b0;
    pl_en  = 1'b0; pl_addr = '0; pl_data = '0;
    idle_inputs();
    req = 3'b111; we = 3'b111; addr0 = 8'd7; wdata0 = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = pa[i]; pl_data = pd[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
    checks++; if (rdata !== 6'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", ram_wren); end
    checks++; if (ram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
    checks++; if (ram_data !== 6'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", ram_data); end
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_read();
    @(negedge clk);
    req = 3'b100; we = 3'b000; addr2 = 8'd5;
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL read_gnt: got %b expected 100", gnt); end
    checks++; if (ram_addr !== 8'd5) begin errors++; $display("FAIL read_ram_addr: got %0d expected 5", ram_addr); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL read_wren: got %b expected 0", ram_wren); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL read_rvalid: got %b expected 100", rvalid); end
    checks++; if (rdata !== 6'h2A) begin errors++; $display("FAIL read_rdata: got %h expected 2a", rdata); end
    @(negedge clk);
    #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL read_rvalid_pulse: got %b expected 000", rvalid); end
    checks++; if (rdata !== 6'h2A) begin errors++; $display("FAIL read_rdata_hold: got %h expected 2a", rdata); end
  endtask

  task automatic test_lock();
    logic [7:0] wa [4];
    logic [5:0] wd [4];
    logic [2:0] exp;
    wa[0] = 8'd10; wd[0] = 6'h11;
    wa[1] = 8'd11; wd[1] = 6'h22;
    wa[2] = 8'd20; wd[2] = 6'h33;
    wa[3] = 8'd21; wd[3] = 6'h3C;
    addr1 = 8'd50; wdata1 = 6'h05;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req = 3'b011; we = 3'b011;
      addr0 = wa[i]; wdata0 = wd[i];
      lock = (i < 3) ? 3'b001 : 3'b000;
      #1;
      exp = 3'b001;
`ifdef BOARD_ARB_RR_EN
      if (i == 3) exp = 3'b010;
`endif
      checks++; if (gnt !== exp) begin errors++; $display("FAIL lock_gnt%0d: got %b expected %b", i, gnt, exp); end
    end
    @(negedge clk);
`ifdef BOARD_ARB_RR_EN
    req = 3'b001; exp = 3'b001;
`else
    req = 3'b010; exp = 3'b010;
`endif
    #1;
    checks++; if (gnt !== exp) begin errors++; $display("FAIL lock_release_gnt: got %b expected %b", gnt, exp); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[wa[i]] !== wd[i]) begin errors++; $display("FAIL lock_ram%0d: got %h expected %h", i, mem[wa[i]], wd[i]); end
    end
    checks++; if (mem[50] !== 6'h05) begin errors++; $display("FAIL lock_ram_req1: got %h expected 05", mem[50]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ord [3];
    logic [5:0] dat [3];
    logic [2:0] exp;
`ifdef BOARD_ARB_RR_EN
    ord[0] = 2'd1; ord[1] = 2'd2; ord[2] = 2'd0;
`else
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2;
`endif
    dat[0] = 6'h11; dat[1] = 6'h22; dat[2] = 6'h33;
    @(negedge clk);
    req = 3'b001; we = 3'b000; lock = 3'b000; addr0 = 8'd21;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL b2b_first_gnt: got %b expected 001", gnt); end
    @(negedge clk);
    req = 3'b111; addr0 = 8'd10; addr1 = 8'd11; addr2 = 8'd20;
    #1;
    checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL b2b_first_rvalid: got %b expected 001", rvalid); end
    checks++; if (rdata !== 6'h3C) begin errors++; $display("FAIL b2b_first_rdata: got %h expected 3c", rdata); end
    for (int k = 0; k < 3; k++) begin
      exp = 3'b000; exp[ord[k]] = 1'b1;
      #1;
      checks++; if (gnt !== exp) begin errors++; $display("FAIL contend_gnt%0d: got %b expected %b", k, gnt, exp); end
      @(negedge clk);
      req[ord[k]] = 1'b0;
      #1;
      checks++; if (rvalid !== exp) begin errors++; $display("FAIL contend_rvalid%0d: got %b expected %b", k, rvalid, exp); end
      checks++; if (rdata !== dat[ord[k]]) begin errors++; $display("FAIL contend_rdata%0d: got %h expected %h", k, rdata, dat[ord[k]]); end
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    req = 3'b010; we = 3'b010; addr1 = 8'd200; wdata1 = 6'h3F;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL oor_wr_gnt: got %b expected 010", gnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", err); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL oor_wr_wren: got %b expected 0", ram_wren); end
    @(negedge clk);
    req = 3'b001; we = 3'b001; addr0 = 8'd199; wdata0 = 6'h0A;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL edge_wr_err: got %b expected 0", err); end
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL edge_wr_wren: got %b expected 1", ram_wren); end
    @(negedge clk);
    req = 3'b100; we = 3'b000; addr2 = 8'd255;
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL oor_rd_gnt: got %b expected 100", gnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b expected 1", err); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL oor_rd_rvalid: got %b expected 100", rvalid); end
    checks++; if (rdata !== 6'h00) begin errors++; $display("FAIL oor_rd_rdata: got %h expected 00", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0", err); end
    checks++; if (mem[200] !== 6'h07) begin errors++; $display("FAIL oor_ram200: got %h expected 07", mem[200]); end
    checks++; if (mem[199] !== 6'h0A) begin errors++; $display("FAIL edge_ram199: got %h expected 0a", mem[199]); end
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk);
    req = 3'b100; we = 3'b000; lock = 3'b100; addr2 = 8'd5;
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rst_pre_gnt: got %b expected 100", gnt); end
    @(posedge clk);
    #1;
    req = 3'b110; we = 3'b010; addr1 = 8'd60; wdata1 = 6'h01;
    resetn = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rst_mid_rvalid: got %b expected 000", rvalid); end
    checks++; if (rdata !== 6'h00) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 00", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b expected 0", err); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_mid_wren: got %b expected 0", ram_wren); end
    checks++; if (ram_addr !== 8'd0) begin errors++; $display("FAIL rst_mid_addr: got %0d expected 0", ram_addr); end
    checks++; if (ram_data !== 6'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", ram_data); end
    @(negedge clk);
    resetn = 1'b1;
    req = 3'b010;
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rst_release_gnt: got %b expected 010", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rst_release_rvalid: got %b expected 000", rvalid); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rst_after_rvalid: got %b expected 000", rvalid); end
    checks++; if (mem[60] !== 6'h01) begin errors++; $display("FAIL rst_after_ram60: got %h expected 01", mem[60]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read();
    test_lock();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_lock();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_ram_arb.md
BOARD_RAM_ARB -- requirements
Module: board_ram_arb

Interface
REQ-001 The module SHALL have these parameters: AW, default 8, RAM address width; DW, default 6, RAM cell width; DEPTH, default 200, valid board cells (10x20).
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on clk.
REQ-003 The module SHALL have these ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req[2:0]  in  3  access request; 0 = piece writer, 1 = line clearer, 2 = collision/render reader
- we[2:0]  in  3  per-requester write enable; 0 = read
- lock[2:0]  in  3  hold ownership after the current access
- addr0/addr1/addr2  in  AW each  per-requester address
- wdata0/wdata1/wdata2  in  DW each  per-requester write data
- gnt[2:0]  out  3  one-hot; access accepted this cycle
- rvalid[2:0]  out  3  one-hot; rdata valid for that requester
- rdata  out  DW  shared read data
- err  out  1  pulse; accepted access had addr >= DEPTH
- ram_addr  out  AW  to single-port RAM
- ram_wren  out  1  RAM write enable
- ram_data  out  DW  RAM write data
- ram_q  in  DW  RAM read data, one-cycle registered latency

Function
REQ-004 At most one gnt bit SHALL be high per cycle; gnt SHALL be combinational from req and arbiter state.
REQ-005 A requester SHALL hold req, we, addr and wdata stable until its gnt is sampled high; each gnt accepts exactly one access.
REQ-006 In the grant cycle, ram_addr, ram_wren and ram_data SHALL be driven combinationally from the granted requester; ram_wren SHALL be 0 when nothing is granted.
REQ-007 For a granted read, rvalid of that requester SHALL pulse exactly one cycle after gnt, with rdata = ram_q; rdata SHALL hold its last value otherwise.
REQ-008 The controller SHALL run the FSM states IDLE (no owner) and OWNED (owner register valid).
REQ-009 IDLE -> OWNED SHALL occur when a grant is issued with the grantee's lock high; OWNED -> IDLE SHALL occur on the first cycle the owner's lock is low.
REQ-010 In OWNED, only the owner SHALL be granted, even if other requesters are pending; the owner's request SHALL be granted every cycle it is high.
REQ-011 In IDLE, the winner SHALL be chosen by fixed priority 0 > 1 > 2, unless BOARD_ARB_RR_EN is defined.
REQ-012 An access with addr >= DEPTH SHALL be granted but SHALL produce ram_wren = 0 and a one-cycle err pulse in the grant cycle.
REQ-013 For an out-of-range read, rvalid SHALL still pulse one cycle later, with rdata = 0.
REQ-014 Back-to-back grants SHALL be supported, one per cycle; a read followed by any access SHALL not stall.
REQ-015 If a requester drops lock and raises req in the same cycle, it SHALL be arbitrated as in IDLE that cycle.

Reset
REQ-016 While resetn is low, the outputs SHALL be: gnt = 0, rvalid = 0, rdata = 0, err = 0, ram_wren = 0, ram_addr = 0, ram_data = 0.
REQ-017 While resetn is low, the FSM SHALL be IDLE and the round-robin pointer SHALL select requester 0.
REQ-018 A reset asserted mid-lock SHALL release ownership, and a pending rvalid SHALL be discarded.

Configuration
REQ-019 With BOARD_ARB_RR_EN defined, IDLE arbitration SHALL be round-robin, with the search starting one above the last granted index (wrapping 2 -> 0).
REQ-020 Without BOARD_ARB_RR_EN, the pointer SHALL be absent and fixed priority SHALL apply.

Structure
REQ-021 A shared package SHALL hold the requester index constants (REQ_PIECE = 0, REQ_CLEAR = 1, REQ_READ = 2), the FSM state encoding, and the default AW, DW and DEPTH.
REQ-022 The sub-module arb_pick SHALL implement the priority/round-robin selector: request vector and pointer in, one-hot grant out.

Verification
REQ-023 Read: reset, then req[2] = 1, we = 0, addr2 = 5 with RAM[5] = 6'h2A -> gnt = 3'b100 that cycle; rvalid = 3'b100 and rdata = 6'h2A next cycle.
REQ-024 Contention: req = 3'b111 simultaneously, fixed priority -> grants 0, 1, 2 in consecutive cycles; with BOARD_ARB_RR_EN and last grant 0, the order SHALL be 1, 2, 0.
REQ-025 Lock: requester 0 writes addresses 10, 11, 20, 21 with lock high while req[1] is held -> req1 is not granted until the cycle after lock0 falls; RAM holds the 4 writes.
REQ-026 Out of range: requester 1 writes addr 200 -> gnt[1] = 1, err = 1, ram_wren = 0; a read of addr 255 -> rvalid with rdata = 0.
REQ-027 Reset: resetn is pulsed low during an owned lock and an in-flight read -> all outputs are 0 immediately, with no rvalid afterwards; the FSM returns to IDLE.
